// File: rtl/pwr_cntr_bank.sv
// pwr_cntr_bank: per-channel transition counters for library-cell activity
// monitoring. Each SIG bit is compared against its previous sample; every
// change (either direction) bumps that channel's counter while ENB is high.
//
// Optional feature: define PWR_CNTR_SAT_EN to make counters saturate at
// all-ones instead of wrapping. OVF is sticky in both builds.
//
// Read handshake: RD is a single-cycle request with DIR as the address.
// Exactly one cycle later VLD pulses high with DATO (and ERR for an
// out-of-range DIR). There is no ready/backpressure; every RD produces one
// VLD unless RST intervenes, and DATO holds between reads.
module pwr_cntr_bank #(
  parameter int NCH = 5,
  parameter int CW  = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ENB,
  input  logic [NCH-1:0] SIG,
  input  logic          CLR,
  input  logic          RD,
  input  logic [2:0]    DIR,
  output logic [CW-1:0] DATO,
  output logic          VLD,
  output logic          ERR,
  output logic [NCH-1:0] OVF,
  output logic          DBG_ST
);

`ifdef PWR_CNTR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           count_ok;
  logic [NCH-1:0] prev_sig;
  logic [NCH-1:0] trans;
  logic [CW-1:0]  cnt [NCH];
  logic [CW-1:0]  rd_data;
  logic           addr_ok;

  assign DBG_ST = state;
  assign trans  = SIG ^ prev_sig;

  // State register: PRIME for one cycle after reset, then RUN forever.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_PRIME;
    else     state <= state_nxt;
  end

  // Next state and count qualifier; PRIME only loads the previous samples.
  always_comb begin
    state_nxt = state;
    count_ok  = 1'b0;
    case (state)
      ST_PRIME: state_nxt = ST_RUN;
      ST_RUN:   count_ok  = ENB & ~CLR;
      default:  state_nxt = ST_PRIME;
    endcase
  end

  // Previous-sample registers track SIG every cycle regardless of ENB.
  always_ff @(posedge CLK) begin
    if (RST) prev_sig <= '0;
    else     prev_sig <= SIG;
  end

  // Counters and sticky overflow flags; CLR beats a coincident transition.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      OVF <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (count_ok && trans[i]) begin
          if (cnt[i] == '1) begin
            OVF[i] <= 1'b1;
            cnt[i] <= SAT ? cnt[i] : '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  // Read mux: selects the pre-update counter value, zero for a bad address.
  always_comb begin
    rd_data = '0;
    addr_ok = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(DIR) == i) begin
        rd_data = cnt[i];
        addr_ok = 1'b1;
      end
    end
  end

  // Read response register: fixed one-cycle latency, DATO held between reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DATO <= '0;
      VLD  <= 1'b0;
      ERR  <= 1'b0;
    end else begin
      VLD <= RD;
      ERR <= RD & ~addr_ok;
      if (RD) DATO <= rd_data;
    end
  end

endmodule

// File: tb/tb_pwr_cntr_bank.sv
// Bench for pwr_cntr_bank built with CW=4 so overflow is reached quickly.
// The reference model keeps an unbounded transition total per channel and
// derives counter value and overflow from it arithmetically.
module tb_pwr_cntr_bank;
  localparam int NCH  = 5;
  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;
`ifdef PWR_CNTR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           ENB = 1'b0;
  logic [NCH-1:0] SIG = '0;
  logic           CLR = 1'b0;
  logic           RD  = 1'b0;
  logic [2:0]     DIR = '0;
  logic [CW-1:0]  DATO;
  logic           VLD;
  logic           ERR;
  logic [NCH-1:0] OVF;
  logic           DBG_ST;

  pwr_cntr_bank #(.NCH(NCH), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .ENB(ENB), .SIG(SIG), .CLR(CLR), .RD(RD),
    .DIR(DIR), .DATO(DATO), .VLD(VLD), .ERR(ERR), .OVF(OVF), .DBG_ST(DBG_ST)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // scoreboard state: {err, data}
  logic [CW:0]    exp_q[$];
  int             tests  = 0;
  int             fails  = 0;
  bit             mon_en = 1'b0;
  int             tot [NCH];
  logic [NCH-1:0] m_prev;
  bit             m_prime;
  logic [NCH-1:0] exp_ovf;
  logic [CW-1:0]  hold;
  logic [NCH-1:0] cur_sig;

  function automatic logic [CW-1:0] mval(input int t);
    if (SAT) return (t > MAXV) ? CW'(MAXV) : CW'(t);
    else     return CW'(t % (MAXV + 1));
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // driver: applies one cycle of inputs and advances the model for that edge
  task automatic step(input logic rst, input logic enb, input logic [NCH-1:0] sig,
                      input logic clr, input logic rd, input logic [2:0] dir);
    @(negedge CLK);
    RST = rst; ENB = enb; SIG = sig; CLR = clr; RD = rd; DIR = dir;
    if (rst) begin
      for (int i = 0; i < NCH; i++) tot[i] = 0;
      m_prev  = '0;
      m_prime = 1'b1;
      exp_ovf = '0;
      hold    = '0;
      exp_q.delete();
      mon_en  = 1'b1;
    end else begin
      if (rd) begin
        if (int'(dir) < NCH) exp_q.push_back({1'b0, mval(tot[int'(dir)])});
        else                 exp_q.push_back({1'b1, {CW{1'b0}}});
      end
      for (int i = 0; i < NCH; i++) begin
        if (clr) tot[i] = 0;
        else if (!m_prime && enb && (sig[i] != m_prev[i])) tot[i]++;
        exp_ovf[i] = (tot[i] > MAXV);
      end
      m_prev  = sig;
      m_prime = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, cur_sig, 0, 0, 3'd0);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) step(1, 0, cur_sig, 0, 0, 3'd0);
  endtask

  task automatic tog(input logic enb, input logic [NCH-1:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      cur_sig = cur_sig ^ mask;
      step(0, enb, cur_sig, 0, 0, 3'd0);
    end
  endtask

  task automatic rd(input logic [2:0] dir);
    step(0, 1, cur_sig, 0, 1, dir);
  endtask

  // monitor: pops the scoreboard whenever a response is due
  always @(posedge CLK) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        logic [CW:0] e;
        e = exp_q.pop_front();
        check("vld", int'(VLD), 1);
        check("dato", int'(DATO), int'(e[CW-1:0]));
        check("err", int'(ERR), int'(e[CW]));
        hold = e[CW-1:0];
      end else begin
        check("vld_idle", int'(VLD), 0);
        check("err_idle", int'(ERR), 0);
        check("dato_hold", int'(DATO), int'(hold));
      end
      check("ovf", int'(OVF), int'(exp_ovf));
    end
  end

  initial begin
    cur_sig = '0;
    // toggle one channel ten times after priming
    rst_cycles(2);
    idle(1);
    tog(1, 5'b00001, 10);
    for (int d = 0; d < NCH; d++) rd(3'(d));

    // all-ones held through reset release: priming swallows it
    cur_sig = 5'b11111;
    rst_cycles(2);
    idle(5);
    for (int d = 0; d < NCH; d++) rd(3'(d));

    // disabled toggles are not counted
    cur_sig = '0;
    rst_cycles(1);
    idle(1);
    tog(0, 5'b00100, 6);
    tog(1, 5'b00100, 4);
    rd(3'd2);

    // overflow on channel 3, then clear
    rst_cycles(1);
    idle(1);
    tog(1, 5'b01000, 20);
    rd(3'd3);
    step(0, 1, cur_sig, 1, 0, 3'd0);
    rd(3'd3);

    // bad address, then read coincident with clear
    rd(3'd6);
    rd(3'd7);
    rst_cycles(1);
    idle(1);
    tog(1, 5'b00001, 7);
    step(0, 1, cur_sig, 1, 1, 3'd0);
    rd(3'd0);

    // reset after a read, and reset coincident with a read
    tog(1, 5'b10010, 3);
    rd(3'd1);
    step(1, 1, cur_sig, 0, 1, 3'd1);
    idle(1);
    rd(3'd4);
    step(1, 1, cur_sig, 1, 1, 3'd4);
    idle(1);

    // simultaneous transitions on every channel
    tog(1, 5'b11111, 5);
    rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic r, e, c, q;
      r = ($urandom_range(0, 149) == 0);
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      q = ($urandom_range(0, 1) == 1);
      cur_sig = cur_sig ^ NCH'($urandom_range(0, 31));
      step(r, e, cur_sig, c, q, 3'($urandom_range(0, 7)));
    end

    idle(3);
    @(posedge CLK);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
